// File: rtl/codec_cfg_pkg.sv
// rtl/codec_cfg_pkg.sv - shared states, constants and init table for the WM8731 config sequencer
package codec_cfg_pkg;

    typedef enum logic [2:0] {
        S_PWR,
        S_LOAD,
        S_GO,
        S_WAIT_END,
        S_GAP,
        S_IDLE,
        S_VOL
    } state_t;

    localparam logic [7:0]  DEV_ADDR      = 8'h34;
    localparam logic [3:0]  INIT_LEN      = 4'd10;
    localparam logic [15:0] VOL_WORD_BASE = 16'h0500;

    // Words 2 and 3 carry the live headphone volume, so the table is a function of it.
    function automatic logic [15:0] init_word(input logic [3:0] index, input logic [6:0] vol);
        logic [15:0] vol_ext;
        vol_ext = {9'd0, vol};
        case (index)
            4'd0:    init_word = 16'h001A;
            4'd1:    init_word = 16'h021A;
            4'd2:    init_word = 16'h0400 | vol_ext;
            4'd3:    init_word = 16'h0600 | vol_ext;
            4'd4:    init_word = 16'h0812;
            4'd5:    init_word = 16'h0A06;
            4'd6:    init_word = 16'h0C00;
            4'd7:    init_word = 16'h0E01;
            4'd8:    init_word = 16'h1002;
            4'd9:    init_word = 16'h1201;
            default: init_word = 16'h0000;
        endcase
    endfunction

endpackage

// File: rtl/codec_cfg_sequencer_vol_stepper.sv
// rtl/codec_cfg_sequencer_vol_stepper.sv - saturating headphone volume register with change detect
module vol_stepper #(
    parameter logic [6:0] VOL_DEFAULT = 7'd121,
    parameter logic [6:0] VOL_MIN     = 7'd48,
    parameter logic [6:0] VOL_MAX     = 7'd127,
    parameter logic [6:0] VOL_STEP    = 7'd3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       dn,
    output logic [6:0] vol,
    output logic       changed
);

    logic [7:0] up_sum;
    logic [7:0] dn_floor;
    logic [6:0] vol_next;

    // 8-bit arithmetic so neither direction can wrap before the clamp is applied.
    always_comb begin
        up_sum   = {1'b0, vol} + {1'b0, VOL_STEP};
        dn_floor = {1'b0, VOL_MIN} + {1'b0, VOL_STEP};
        vol_next = vol;
        if (en && up && !dn) begin
            vol_next = (up_sum > {1'b0, VOL_MAX}) ? VOL_MAX : up_sum[6:0];
        end else if (en && dn && !up) begin
            vol_next = ({1'b0, vol} < dn_floor) ? VOL_MIN : (vol - VOL_STEP);
        end
    end

    assign changed = (vol_next != vol);

    always_ff @(posedge clk) begin
        if (rst) begin
            vol <= VOL_DEFAULT;
        end else begin
            vol <= vol_next;
        end
    end

endmodule

// File: rtl/codec_cfg_sequencer.sv
// rtl/codec_cfg_sequencer.sv - WM8731 power-up table writer and headphone volume updater over I2C
module codec_cfg_sequencer
    import codec_cfg_pkg::*;
#(
    parameter int         INIT_DELAY  = 50000,
    parameter int         GAP_CYCLES  = 1000,
    parameter int         MAX_RETRY   = 3,
    parameter logic [6:0] VOL_DEFAULT = 7'd121,
    parameter logic [6:0] VOL_MIN     = 7'd48,
    parameter logic [6:0] VOL_MAX     = 7'd127,
    parameter logic [6:0] VOL_STEP    = 7'd3
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iVOL_UP,
    input  logic        iVOL_DN,
    output logic [23:0] oI2C_DATA,
    output logic        oI2C_GO,
    input  logic        iI2C_END,
    input  logic        iI2C_ACK,
    output logic [6:0]  oVOL,
    output logic        oBUSY,
    output logic        oCFG_DONE,
    output logic        oERR
);

    localparam int CNT_MAX = (INIT_DELAY > GAP_CYCLES) ? INIT_DELAY : GAP_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    localparam logic [CNT_W-1:0]   PWR_LAST  = CNT_W'(INIT_DELAY - 1);
    localparam logic [CNT_W-1:0]   GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(MAX_RETRY);

    state_t             state, state_n;
    logic [3:0]         index, index_n;
    logic [RETRY_W-1:0] retry, retry_n;
    logic [CNT_W-1:0]   cnt, cnt_n;
    logic [23:0]        data_n;
    logic               go_n, done_n, err_n;
    logic               in_init, in_init_n;
    logic               resend, resend_n;
    logic               abort, abort_n;
    logic               vol_pending, pend_n, pend_clr;
    logic               vol_changed;

    vol_stepper #(
        .VOL_DEFAULT (VOL_DEFAULT),
        .VOL_MIN     (VOL_MIN),
        .VOL_MAX     (VOL_MAX),
        .VOL_STEP    (VOL_STEP)
    ) u_vol (
        .clk     (iCLK),
        .rst     (iRST),
        .en      (state != S_PWR),
        .up      (iVOL_UP),
        .dn      (iVOL_DN),
        .vol     (oVOL),
        .changed (vol_changed)
    );

    assign oBUSY = (state != S_IDLE);

    always_comb begin
        state_n   = state;
        index_n   = index;
        retry_n   = retry;
        cnt_n     = cnt;
        data_n    = oI2C_DATA;
        go_n      = oI2C_GO;
        done_n    = oCFG_DONE;
        err_n     = oERR;
        in_init_n = in_init;
        resend_n  = resend;
        abort_n   = abort;
        pend_clr  = 1'b0;
        case (state)
            S_PWR: begin
                if (cnt == PWR_LAST) begin
                    cnt_n   = '0;
                    state_n = S_LOAD;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_LOAD: begin
                data_n   = {DEV_ADDR, init_word(index, oVOL)};
                // Words 2/3 already carry the current volume, so a pending update is redundant.
                pend_clr = (index == 4'd2) || (index == 4'd3);
                state_n  = S_GO;
            end
            S_GO: begin
                go_n    = 1'b1;
                state_n = S_WAIT_END;
            end
            S_WAIT_END: begin
                if (iI2C_END) begin
                    go_n    = 1'b0;
                    state_n = S_GAP;
                    if (iI2C_ACK) begin
                        retry_n  = '0;
                        resend_n = 1'b0;
                        if (in_init) index_n = index + 4'd1;
                    end else if (retry < RETRY_LIM) begin
                        retry_n  = retry + RETRY_W'(1);
                        resend_n = 1'b1;
                    end else begin
                        retry_n  = '0;
                        resend_n = 1'b0;
                        abort_n  = 1'b1;
                        err_n    = 1'b1;
                    end
                end
            end
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    cnt_n = '0;
                    if (abort) begin
                        abort_n   = 1'b0;
                        in_init_n = 1'b0;
                        state_n   = S_IDLE;
                    end else if (resend) begin
                        // oI2C_DATA still holds the NACKed word.
                        state_n = S_GO;
                    end else if (in_init && (index < INIT_LEN)) begin
                        state_n = S_LOAD;
                    end else begin
                        if (in_init) done_n = 1'b1;
                        in_init_n = 1'b0;
                        state_n   = S_IDLE;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_IDLE: begin
                if (vol_pending) state_n = S_VOL;
            end
            S_VOL: begin
                data_n   = {DEV_ADDR, VOL_WORD_BASE | {9'd0, oVOL}};
                pend_clr = 1'b1;
                state_n  = S_GO;
            end
            default: state_n = S_PWR;
        endcase
        // A request landing on the same edge as a load is newer than the loaded word.
        if (vol_changed)   pend_n = 1'b1;
        else if (pend_clr) pend_n = 1'b0;
        else               pend_n = vol_pending;
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state       <= S_PWR;
            index       <= '0;
            retry       <= '0;
            cnt         <= '0;
            oI2C_DATA   <= '0;
            oI2C_GO     <= 1'b0;
            oCFG_DONE   <= 1'b0;
            oERR        <= 1'b0;
            in_init     <= 1'b1;
            resend      <= 1'b0;
            abort       <= 1'b0;
            vol_pending <= 1'b0;
        end else begin
            state       <= state_n;
            index       <= index_n;
            retry       <= retry_n;
            cnt         <= cnt_n;
            oI2C_DATA   <= data_n;
            oI2C_GO     <= go_n;
            oCFG_DONE   <= done_n;
            oERR        <= err_n;
            in_init     <= in_init_n;
            resend      <= resend_n;
            abort       <= abort_n;
            vol_pending <= pend_n;
        end
    end

endmodule

// File: tb/tb_codec_cfg_sequencer.sv
// tb/tb_codec_cfg_sequencer.sv - self-checking bench for codec_cfg_sequencer
module tb_codec_cfg_sequencer;

    localparam int INIT_DELAY = 20;
    localparam int GAP_CYCLES = 5;
    localparam int SLAVE_LAT  = 3;

    logic        iCLK = 1'b0;
    logic        iRST = 1'b1;
    logic        iVOL_UP = 1'b0;
    logic        iVOL_DN = 1'b0;
    logic        iI2C_END = 1'b0;
    logic        iI2C_ACK = 1'b0;
    logic [23:0] oI2C_DATA;
    logic        oI2C_GO;
    logic [6:0]  oVOL;
    logic        oBUSY;
    logic        oCFG_DONE;
    logic        oERR;

    typedef struct {
        logic        up;
        logic        dn;
        logic [6:0]  exp_vol;
        logic        has_write;
        logic [23:0] exp_write;
        logic        settle;
    } vec_t;

    int          compared = 0;
    int          mismatched = 0;
    logic [23:0] exp_q[$];
    logic [23:0] last_write = '0;
    logic [23:0] nack_word = 24'hFFFFFF;
    int          nack_left = 0;
    logic        go_prev = 1'b0;
    logic [15:0] init_tab [10];
    vec_t        vecs[$];

    always #10 iCLK = ~iCLK;

    codec_cfg_sequencer #(
        .INIT_DELAY (INIT_DELAY),
        .GAP_CYCLES (GAP_CYCLES),
        .MAX_RETRY  (3)
    ) dut (
        .iCLK      (iCLK),
        .iRST      (iRST),
        .iVOL_UP   (iVOL_UP),
        .iVOL_DN   (iVOL_DN),
        .oI2C_DATA (oI2C_DATA),
        .oI2C_GO   (oI2C_GO),
        .iI2C_END  (iI2C_END),
        .iI2C_ACK  (iI2C_ACK),
        .oVOL      (oVOL),
        .oBUSY     (oBUSY),
        .oCFG_DONE (oCFG_DONE),
        .oERR      (oERR)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every rising oI2C_GO must match the oldest expected word.
    always @(negedge iCLK) begin
        if (oI2C_GO && !go_prev) begin
            last_write = oI2C_DATA;
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_write: got 0x%0h, expected no write", oI2C_DATA);
            end else begin
                check("write_word", oI2C_DATA, exp_q.pop_front());
            end
        end
        go_prev = oI2C_GO;
    end

    // I2C slave: answers each GO after SLAVE_LAT cycles, NACKing nack_word nack_left times.
    initial begin
        forever begin
            @(negedge iCLK);
            if (oI2C_GO) begin
                repeat (SLAVE_LAT) @(negedge iCLK);
                iI2C_ACK = !((oI2C_DATA == nack_word) && (nack_left > 0));
                if (!iI2C_ACK) nack_left--;
                iI2C_END = 1'b1;
                @(negedge iCLK);
                iI2C_END = 1'b0;
                iI2C_ACK = 1'b0;
                while (oI2C_GO) @(negedge iCLK);
            end
        end
    end

    task automatic push_word(input int i, input logic [6:0] vol);
        logic [15:0] w;
        w = init_tab[i];
        if (i == 2 || i == 3) w = w | {9'd0, vol};
        exp_q.push_back({8'h34, w});
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while ((oBUSY || exp_q.size() != 0) && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        check({name, "_settled"}, 32'(oBUSY || exp_q.size() != 0), 0);
        repeat (3) @(negedge iCLK);
    endtask

    task automatic wait_go(input string name, input logic [23:0] word, input int budget);
        int n;
        n = 0;
        while (!(oI2C_GO && oI2C_DATA == word) && n < budget) begin
            @(negedge iCLK);
            n++;
        end
        check({name, "_seen"}, 32'(oI2C_GO && oI2C_DATA == word), 1);
    endtask

    task automatic start_reset();
        iRST = 1'b1;
        iVOL_UP = 1'b0;
        iVOL_DN = 1'b0;
        repeat (2) @(negedge iCLK);
        exp_q.delete();
    endtask

    function automatic vec_t mk(input logic up, input logic dn, input logic [6:0] v,
                                input logic hw, input logic [23:0] w, input logic st);
        vec_t r;
        r.up = up; r.dn = dn; r.exp_vol = v; r.has_write = hw; r.exp_write = w; r.settle = st;
        return r;
    endfunction

    initial begin
        int prev;
        int v;
        init_tab = '{16'h001A, 16'h021A, 16'h0400, 16'h0600, 16'h0812,
                     16'h0A06, 16'h0C00, 16'h0E01, 16'h1002, 16'h1201};

        // Three consecutive-cycle ups from 121: clamps at 127, one coalesced write.
        vecs.push_back(mk(1'b1, 1'b0, 7'd124, 1'b1, 24'h34057F, 1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 7'd127, 1'b0, 24'h0,      1'b0));
        vecs.push_back(mk(1'b1, 1'b0, 7'd127, 1'b0, 24'h0,      1'b1));
        // Both at once: no change; then 30 paced downs saturating at 48.
        vecs.push_back(mk(1'b1, 1'b1, 7'd127, 1'b0, 24'h0,      1'b1));
        prev = 127;
        for (int k = 1; k <= 30; k++) begin
            v = 127 - 3 * k;
            if (v < 48) v = 48;
            vecs.push_back(mk(1'b0, 1'b1, 7'(v), 1'b1 && (v != prev), {16'h3405, 1'b0, 7'(v)}, 1'b1));
            prev = v;
        end

        // Reset state and a clean init run.
        start_reset();
        check("rst_go",   oI2C_GO,   0);
        check("rst_data", oI2C_DATA, 0);
        check("rst_vol",  oVOL,      121);
        check("rst_done", oCFG_DONE, 0);
        check("rst_err",  oERR,      0);
        check("rst_busy", oBUSY,     1);
        for (int i = 0; i < 10; i++) push_word(i, 7'd121);
        iRST = 1'b0;
        repeat (4) @(negedge iCLK);
        iVOL_UP = 1'b1;
        @(negedge iCLK);
        iVOL_UP = 1'b0;
        @(negedge iCLK);
        check("pwr_vol_ignored", oVOL, 121);
        repeat (8) @(negedge iCLK);
        check("pwr_no_go",   oI2C_GO, 0);
        check("pwr_busy",    oBUSY,   1);
        wait_idle("init", 2000);
        check("init_done",   oCFG_DONE, 1);
        check("init_err",    oERR,      0);
        check("init_busy",   oBUSY,     0);
        check("init_last",   last_write, 24'h341201);

        // One NACK on word 4: resent once, table completes.
        start_reset();
        nack_word = 24'h340812;
        nack_left = 1;
        for (int i = 0; i < 5; i++) push_word(i, 7'd121);
        for (int i = 4; i < 10; i++) push_word(i, 7'd121);
        iRST = 1'b0;
        wait_idle("nack1", 2000);
        check("nack1_done", oCFG_DONE, 1);
        check("nack1_err",  oERR,      0);

        // Word 4 NACKed on every attempt: four sends, then error and idle.
        start_reset();
        nack_left = 4;
        for (int i = 0; i < 4; i++) push_word(i, 7'd121);
        for (int i = 0; i < 4; i++) push_word(4, 7'd121);
        iRST = 1'b0;
        wait_idle("nack4", 2000);
        repeat (40) @(negedge iCLK);
        check("nack4_err",  oERR,      1);
        check("nack4_done", oCFG_DONE, 0);
        check("nack4_busy", oBUSY,     0);
        nack_word = 24'hFFFFFF;
        nack_left = 0;

        // Volume vector table, applied from S_IDLE at 121.
        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].has_write) exp_q.push_back(vecs[i].exp_write);
            iVOL_UP = vecs[i].up;
            iVOL_DN = vecs[i].dn;
            @(negedge iCLK);
            iVOL_UP = 1'b0;
            iVOL_DN = 1'b0;
            check($sformatf("vec%0d_vol", i), oVOL, vecs[i].exp_vol);
            if (vecs[i].settle) wait_idle($sformatf("vec%0d", i), 500);
        end
        check("vol_floor",      oVOL,       48);
        check("vol_last_write", last_write, 24'h340530);

        // Reset while word 6 is in flight: GO drops, volume restores, table reruns.
        start_reset();
        for (int i = 0; i < 10; i++) push_word(i, 7'd121);
        iRST = 1'b0;
        wait_go("word5", 24'h340A06, 500);
        iVOL_UP = 1'b1;
        @(negedge iCLK);
        iVOL_UP = 1'b0;
        check("mid_vol_up", oVOL, 124);
        wait_go("word6", 24'h340C00, 500);
        iRST = 1'b1;
        @(negedge iCLK);
        check("mid_rst_go",   oI2C_GO,   0);
        check("mid_rst_vol",  oVOL,      121);
        check("mid_rst_done", oCFG_DONE, 0);
        check("mid_rst_busy", oBUSY,     1);
        iRST = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 10; i++) push_word(i, 7'd121);
        repeat (15) @(negedge iCLK);
        check("restart_no_go", oI2C_GO, 0);
        wait_idle("restart", 2000);
        check("restart_done", oCFG_DONE, 1);
        check("restart_vol",  oVOL,      121);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/codec_cfg_sequencer.md
Name: codec_cfg_sequencer

Overview:
Sequences WM8731 audio codec configuration over the existing I2C word-write master. After reset it waits a power-up delay, then writes a fixed 10-entry register table. It then services headphone-volume step requests with saturating volume arithmetic. It drives the I2C master through a GO/END handshake, retries NACKed words, and reports busy, done and error status to the board top level.

Parameters:
INIT_DELAY, 50000, iCLK cycles from reset release to the first write (1 ms at 50 MHz).
GAP_CYCLES, 1000, idle iCLK cycles between consecutive I2C transactions.
MAX_RETRY, 3, re-sends allowed per word after a NACK.
VOL_DEFAULT, 7'd121, volume after reset (0 dB).
VOL_MIN, 7'd48, lower clamp (mute threshold).
VOL_MAX, 7'd127, upper clamp.
VOL_STEP, 7'd3, change per request.

Ports:
iCLK  in  1  system clock, 50 MHz.
iRST  in  1  synchronous, active-high reset.
iVOL_UP  in  1  single-cycle volume-up request.
iVOL_DN  in  1  single-cycle volume-down request.
oI2C_DATA  out  24  {8'h34, 7-bit reg addr, 9-bit data} to the I2C master.
oI2C_GO  out  1  transaction request, level, held until iI2C_END.
iI2C_END  in  1  single-cycle pulse: transaction finished.
iI2C_ACK  in  1  valid with iI2C_END; 1 = all bytes acknowledged.
oVOL  out  7  current target volume.
oBUSY  out  1  1 whenever state is not S_IDLE.
oCFG_DONE  out  1  sticky; set when the table completes without error.
oERR  out  1  sticky; set when a word exhausts its retries.

Behaviour:
- Reset values (synchronous, iRST=1 at the iCLK edge): oI2C_GO=0, oI2C_DATA=0, oVOL=VOL_DEFAULT, oCFG_DONE=0, oERR=0, oBUSY=1, state=S_PWR, index=0, retry=0, delay counter=0.
- Reset asserted mid-transaction: oI2C_GO drops on the next edge. The whole init table reruns after INIT_DELAY.
- Init table, words 0..9 (16-bit {reg, data}): 0x001A, 0x021A, 0x0400|vol, 0x0600|vol, 0x0812, 0x0A06, 0x0C00, 0x0E01, 0x1002, 0x1201. Here vol is the current oVOL, zero-extended.
- States:
  - S_PWR: count INIT_DELAY cycles, then go to S_LOAD.
  - S_LOAD: oI2C_DATA <= {8'h34, table[index]}, then go to S_GO.
  - S_GO: oI2C_GO=1, then go to S_WAIT_END.
  - S_WAIT_END: hold oI2C_GO and oI2C_DATA stable until iI2C_END. On iI2C_END, oI2C_GO=0 on the next edge.
    - ACK=1: retry <= 0, go to S_GAP.
    - ACK=0 and retry<MAX_RETRY: retry++, go to S_GAP, then resend the same word.
    - ACK=0 and retry==MAX_RETRY: oERR <= 1, abandon the table (oCFG_DONE stays 0), go to S_GAP then S_IDLE.
  - S_GAP: count GAP_CYCLES. Then:
    - resend the same word on a retry;
    - else load the next table index while index<10;
    - else S_IDLE, with oCFG_DONE <= 1 if the table completed.
  - S_IDLE: if vol_pending, go to S_VOL; else stay.
  - S_VOL: oI2C_DATA <= {8'h34, 16'h0500 | oVOL} (LHPOUT with LRHPBOTH=1, zero-cross off; updates both channels). vol_pending <= 0, go to S_GO. Completion follows the same ACK/retry path and returns to S_IDLE.
- Volume requests are accepted in every state except S_PWR, including during init and transactions.
  - Up only: oVOL <= min(oVOL+VOL_STEP, VOL_MAX).
  - Down only: oVOL <= max(oVOL-VOL_STEP, VOL_MIN).
  - Both in the same cycle: no change.
  - Compute in 8 bits to avoid wrap.
  - vol_pending <= 1 only if the clamped value differs from the current value.
- Coalescing: multiple requests while busy collapse into one S_VOL write with the latest oVOL.
- Requests during init: vol_pending is cleared when table words 2 and 3 are loaded, since those words already carry the new volume.
- An iI2C_END outside S_WAIT_END is ignored.

Decomposition:
- Package codec_cfg_pkg: the state enum, the WM8731 device address constant 8'h34, INIT_LEN=10, and the init table as a constant function of vol.
- Sub-module vol_stepper: saturating up/down arithmetic plus pending-flag generation (combinational core, registered oVOL).

Test Plan:
- Reset release, slave always ACKs, INIT_DELAY=20, GAP_CYCLES=5 -> exactly 10 GO transactions in order; word 2 = 24'h340479, word 9 = 24'h341201; then oCFG_DONE=1, oBUSY=0.
- NACK once on word 4 -> 24'h340812 is sent twice, the sequence continues, oCFG_DONE=1, oERR=0.
- NACK word 4 on all MAX_RETRY+1=4 attempts -> 4 sends of 24'h340812, then oERR=1, oCFG_DONE=0, no word 5, state S_IDLE.
- In S_IDLE at oVOL=121, three iVOL_UP pulses 1 cycle apart -> oVOL=127 (clamped), exactly one write of 24'h34057F.
- iVOL_UP and iVOL_DN high in the same cycle, then 30 iVOL_DN pulses -> first no change; finally oVOL=48 with no wrap; the last write is 24'h340530.
- iRST asserted while oI2C_GO=1 during word 6 -> oI2C_GO=0 next cycle, oVOL=121, the flags clear, and the sequence restarts at word 0 after INIT_DELAY.
